// File: rtl/dct_quant_seq.sv
// Sequencer for an 8x8 block of DCT coefficients. It feeds an external
// reciprocal multiplier and tags the results with index and last-of-block.
module dct_quant_seq #(
  parameter int MULT_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blk_start,
  input  logic        qt_sel,
  input  logic        coef_valid,
  input  logic [11:0] coef_data,
  output logic        coef_ready,
  input  logic        qt_we,
  input  logic [6:0]  qt_addr,
  input  logic [7:0]  qt_data,
  output logic [11:0] n1,
  output logic [7:0]  n2,
  input  logic [8:0]  dctq,
  output logic        q_valid,
  output logic [8:0]  q_data,
  output logic [5:0]  q_idx,
  output logic        q_last,
  output logic        blk_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic        sel;
  logic [5:0]  idx;
  logic        accept;
  logic        tag_exit_last;

  logic [7:0]  qt_mem [0:127];

  // Stage 0 lines up with n1/n2; stage MULT_LAT lines up with a valid dctq.
  logic        tag_v    [0:MULT_LAT];
  logic [5:0]  tag_idx  [0:MULT_LAT];
  logic        tag_last [0:MULT_LAT];

  // Tables have no reset so their contents survive an abort.
  always_ff @(posedge clk) begin
    if (qt_we && state == IDLE) begin
      qt_mem[qt_addr] <= qt_data;
    end
  end

  assign busy          = (state != IDLE);
  assign tag_exit_last = tag_v[MULT_LAT] && tag_last[MULT_LAT];

  always_comb begin
    state_next = state;
    coef_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (blk_start) state_next = RUN;
      end
      RUN: begin
        coef_ready = 1'b1;
        accept     = coef_valid;
        if (coef_valid && idx == 6'd63) state_next = DRAIN;
      end
      DRAIN: begin
        if (tag_exit_last) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 1'b0;
      idx   <= 6'd0;
      n1    <= 12'd0;
      n2    <= 8'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && blk_start) begin
        sel <= qt_sel;
        idx <= 6'd0;
      end
      if (accept) begin
        n1  <= coef_data;
        n2  <= qt_mem[{sel, idx}];
        idx <= idx + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= MULT_LAT; i++) begin
        tag_v[i]    <= 1'b0;
        tag_idx[i]  <= 6'd0;
        tag_last[i] <= 1'b0;
      end
    end else begin
      tag_v[0]    <= accept;
      tag_idx[0]  <= idx;
      tag_last[0] <= (idx == 6'd63);
      for (int i = 1; i <= MULT_LAT; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_idx[i]  <= tag_idx[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid  <= 1'b0;
      q_data   <= 9'd0;
      q_idx    <= 6'd0;
      q_last   <= 1'b0;
      blk_done <= 1'b0;
    end else begin
      q_valid  <= tag_v[MULT_LAT];
      q_last   <= tag_exit_last;
      blk_done <= (state == DONE);
      if (tag_v[MULT_LAT]) begin
        q_data <= dctq;
        q_idx  <= tag_idx[MULT_LAT];
      end
    end
  end

endmodule

// File: tb/tb_dct_quant_seq.sv
// Bench for dct_quant_seq: three instances (MULT_LAT 2, 1, 4) share one
// stimulus stream; a scoreboard per instance checks timing and contents.
module tb_dct_quant_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, blk_start, qt_sel, coef_valid, qt_we, exp_start, stim_timeout;
  logic [11:0] coef_data;
  logic [6:0]  qt_addr;
  logic [7:0]  qt_data;

  logic        coef_ready_a [3];
  logic [11:0] n1_a         [3];
  logic [7:0]  n2_a         [3];
  logic [8:0]  dctq_a       [3];
  logic        q_valid_a    [3];
  logic [8:0]  q_data_a     [3];
  logic [5:0]  q_idx_a      [3];
  logic        q_last_a     [3];
  logic        blk_done_a   [3];
  logic        busy_a       [3];

  logic [7:0]  tbl [0:127];
  int          vecs = 0;
  int          errs = 0;
  int          cyc  = 0;

  // Stand-in multiplier: signed coefficient times unsigned reciprocal, scaled by 2^-11.
  function automatic logic [8:0] mulf(input logic [11:0] a, input logic [7:0] b);
    logic signed [20:0] sa, sb, p;
    sa = 21'($signed(a));
    sb = {13'd0, b};
    p  = sa * sb;
    return p[19:11];
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
      logic [8:0] pipe [0:L-1];
      always @(posedge clk) begin
        pipe[0] <= mulf(n1_a[gi], n2_a[gi]);
        for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
      end
      assign dctq_a[gi] = pipe[L-1];

      dct_quant_seq #(.MULT_LAT(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blk_start  (blk_start),
        .qt_sel     (qt_sel),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_ready (coef_ready_a[gi]),
        .qt_we      (qt_we),
        .qt_addr    (qt_addr),
        .qt_data    (qt_data),
        .n1         (n1_a[gi]),
        .n2         (n2_a[gi]),
        .dctq       (dctq_a[gi]),
        .q_valid    (q_valid_a[gi]),
        .q_data     (q_data_a[gi]),
        .q_idx      (q_idx_a[gi]),
        .q_last     (q_last_a[gi]),
        .blk_done   (blk_done_a[gi]),
        .busy       (busy_a[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [8:0] d;
    int         idx;
    int         due;
  } exp_t;

  exp_t        sb [3][$];
  exp_t        e;
  int          exp_idx   [3] = '{64, 64, 64};
  logic        op_pend   [3] = '{1'b0, 1'b0, 1'b0};
  logic [11:0] op_n1     [3];
  logic [7:0]  op_n2     [3];
  logic        prev_last [3] = '{1'b0, 1'b0, 1'b0};
  logic        exp_sel   = 1'b0;
  logic        rst_prev  = 1'b0;
  logic        exp_v;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s dut%0d cyc %0d: got 0x%0h want 0x%0h", nm, i, cyc, act, exp);
    end
  endtask

  // Monitor: sole owner of the scoreboards and counters.
  always @(negedge clk) begin
    cyc++;
    chk("stim_timeout", 0, int'(stim_timeout), 0);
    for (int i = 0; i < 3; i++) begin
      if (rst_prev) begin
        chk("rst_coef_ready", i, int'(coef_ready_a[i]), 0);
        chk("rst_busy",       i, int'(busy_a[i]), 0);
        chk("rst_blk_done",   i, int'(blk_done_a[i]), 0);
        chk("rst_n1",         i, int'(n1_a[i]), 0);
        chk("rst_n2",         i, int'(n2_a[i]), 0);
      end else begin
        if (op_pend[i]) begin
          chk("n1", i, int'(n1_a[i]), int'(op_n1[i]));
          chk("n2", i, int'(n2_a[i]), int'(op_n2[i]));
        end
        chk("blk_done", i, int'(blk_done_a[i]), int'(prev_last[i]));
        if (blk_done_a[i]) chk("busy_after_done", i, int'(busy_a[i]), 0);
        chk("coef_ready", i, int'(coef_ready_a[i]), int'(exp_idx[i] < 64));
      end

      exp_v = (sb[i].size() > 0) && (sb[i][0].due == cyc);
      chk("q_valid", i, int'(q_valid_a[i]), int'(exp_v));
      if (exp_v) begin
        e = sb[i].pop_front();
        if (q_valid_a[i]) begin
          chk("q_data", i, int'(q_data_a[i]), int'(e.d));
          chk("q_idx",  i, int'(q_idx_a[i]), e.idx);
          chk("q_last", i, int'(q_last_a[i]), int'(e.idx == 63));
          chk("busy",   i, int'(busy_a[i]), 1);
        end
      end
      prev_last[i] = q_valid_a[i] && q_last_a[i];

      op_pend[i] = 1'b0;
      if (rst_n && coef_valid && coef_ready_a[i]) begin
        op_pend[i] = 1'b1;
        op_n1[i]   = coef_data;
        op_n2[i]   = tbl[{exp_sel, exp_idx[i][5:0]}];
        e.d   = mulf(coef_data, op_n2[i]);
        e.idx = exp_idx[i];
        e.due = cyc + lat_of(i) + 2;
        sb[i].push_back(e);
        exp_idx[i]++;
      end
      if (rst_n && exp_start && blk_start) exp_idx[i] = 0;
      if (!rst_n) begin
        sb[i].delete();
        exp_idx[i]   = 64;
        prev_last[i] = 1'b0;
        op_pend[i]   = 1'b0;
      end
    end
    if (rst_n && exp_start && blk_start) exp_sel = qt_sel;
    rst_prev = !rst_n;
  end

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    qt_we = 1'b1; qt_addr = a; qt_data = d;
    tbl[a] = d;
    @(posedge clk); #1;
    qt_we = 1'b0;
  endtask

  // mode 0: const 0x555, 1: alternating 0x7ff/0x800, 2: valid every other
  // cycle, 3: stray blk_start and qt_we mid-block. abort_at < 64 pulses reset.
  task automatic run_block(input logic sel, input int mode, input int abort_at);
    int n, c;
    blk_start = 1'b1; qt_sel = sel; exp_start = 1'b1;
    @(posedge clk); #1;
    blk_start = 1'b0; exp_start = 1'b0;
    n = 0; c = 0;
    while (n < 64 && c < 400) begin
      if (n == abort_at) begin
        rst_n = 1'b0; coef_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        break;
      end
      coef_valid = (mode == 2) ? ((c % 2) == 0) : 1'b1;
      coef_data  = (mode == 1) ? (((n % 2) == 0) ? 12'h7ff : 12'h800) : 12'h555;
      blk_start  = (mode == 3 && n == 10);
      qt_we      = (mode == 3 && n == 10);
      qt_addr    = 7'h00;
      qt_data    = 8'h01;
      @(negedge clk);
      if (coef_valid && coef_ready_a[0]) n++;
      @(posedge clk); #1;
      c++;
    end
    if (c >= 400) stim_timeout = 1'b1;
    coef_valid = 1'b0; blk_start = 1'b0; qt_we = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; blk_start = 1'b0; qt_sel = 1'b0; coef_valid = 1'b0;
    coef_data = 12'd0; qt_we = 1'b0; qt_addr = 7'd0; qt_data = 8'd0;
    exp_start = 1'b0; stim_timeout = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 64; k++) wr(7'(k), 8'h55);
    run_block(1'b0, 0, 64);

    for (int k = 0; k < 64; k++) begin
      wr(7'(64 + k), 8'(k + 128));
      wr(7'(k), 8'hff);
    end
    run_block(1'b1, 1, 64);
    run_block(1'b0, 2, 64);
    run_block(1'b0, 3, 64);
    run_block(1'b0, 0, 64);
    run_block(1'b0, 0, 30);
    run_block(1'b0, 1, 64);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dct_quant_seq.md
DCT_QUANT_SEQ -- requirements
Module: dct_quant_seq

Interface
REQ-001 Parameter MULT_LAT, default 2: cycles from n1/n2 presented to dctq valid in the external multiplier; legal 1..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 blk_start  input  1  one-cycle pulse; begins an 8x8 block of 64 coefficients.
REQ-005 qt_sel  input  1  quant table select, sampled with blk_start (0 = luma, 1 = chroma).
REQ-006 coef_valid  input  1  coefficient offered.
REQ-007 coef_data  input  12  signed DCT coefficient.
REQ-008 coef_ready  output  1  coefficient accepted this cycle when high with coef_valid.
REQ-009 qt_we / qt_addr / qt_data  input  1 / 7 / 8  table write: qt_addr = {table, index[5:0]}, qt_data = unsigned reciprocal.
REQ-010 n1  output  12  multiplier signed operand (registered).
REQ-011 n2  output  8  multiplier unsigned operand (registered).
REQ-012 dctq  input  9  multiplier result.
REQ-013 q_valid / q_data / q_idx / q_last  output  1 / 9 / 6 / 1  quantized result, its index, last-of-block flag.
REQ-014 blk_done  output  1  one-cycle pulse, block complete.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Table storage: 2 x 64 x 8-bit; write on qt_we only in IDLE; qt_we outside IDLE is ignored with no side effect.
REQ-017 States: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE -> RUN on blk_start: latch qt_sel, clear index counter to 0.
REQ-019 RUN: coef_ready = 1 (combinational from state); accept = coef_valid & coef_ready.
REQ-020 On accept at edge k: n1 <= coef_data, n2 <= table[sel][idx], idx <= idx+1; n1/n2 hold their last value on non-accept cycles.
REQ-021 Accept of idx 63 -> DRAIN; coef_ready = 0 in DRAIN, DONE, IDLE.
REQ-022 Tag pipeline of depth MULT_LAT carries {valid, idx, last} alongside the multiplier.
REQ-023 For an accept at edge k, at edge k+MULT_LAT+1: q_valid <= 1, q_data <= dctq, q_idx <= idx, q_last <= (idx==63); otherwise q_valid <= 0.
REQ-024 Accept-to-q_valid latency fixed at MULT_LAT+1 cycles; gaps in coef_valid propagate as gaps in q_valid, order preserved.
REQ-025 DRAIN -> DONE on the edge that registers q_last = 1; DONE asserts blk_done for exactly one cycle, then -> IDLE.
REQ-026 blk_start outside IDLE is ignored; blk_start in the DONE cycle is ignored (earliest restart: first IDLE cycle).
REQ-027 q_data is dctq passed unchanged; no width alteration, no saturation in this block.
REQ-028 Exactly 64 q_valid pulses per block, q_idx 0..63 ascending, q_last only on idx 63.

Reset
REQ-029 rst_n low at an edge: state IDLE, idx 0, tag pipeline cleared, n1 = 0, n2 = 0, q_valid/q_data/q_idx/q_last = 0, blk_done = 0, busy = 0.
REQ-030 Reset mid-block aborts it: no further q_valid from in-flight coefficients, no blk_done.
REQ-031 Table contents are not reset and are retained across reset.

Verification
REQ-032 Load table 0 all 0x55; blk_start qt_sel=0; 64 back-to-back coef 0x555 -> n1=0x555, n2=0x55 each cycle; 64 q_valid, idx 0..63, q_last at 63; blk_done one cycle after q_last; busy low after.
REQ-033 Table 1 idx k = k+0x80, table 0 = 0xff; qt_sel=1, coefs alternating 0x7ff/0x800 -> n2 sequence 0x80..0xbf; never 0xff.
REQ-034 coef_valid low on every other cycle -> q_valid pattern mirrors it shifted by MULT_LAT+1; 64 outputs total.
REQ-035 blk_start and qt_we (addr 0x00, data 0x01) pulsed during RUN -> no restart, idx continues; next block with table 0 still gives n2=0xff at idx 0.
REQ-036 rst_n low for one cycle after 30 accepts -> next cycle coef_ready=0, q_valid=0, busy=0, no blk_done; new blk_start restarts at q_idx 0; table still 0xff.
REQ-037 Repeat REQ-032 with MULT_LAT = 1 and 4 -> latency MULT_LAT+1 exactly.
